// File: rtl/satp_pkg.sv
// ---------------------------------------------------------------------------
// satp_pkg
//  Shared definitions for the SV32 SATP switch controller: field layout of
//  the SATP register, MODE encodings, response status codes and FSM states.
//  No ports (package).
// ---------------------------------------------------------------------------
package satp_pkg;

   localparam int SATP_W   = 32;
   localparam int MODE_W   = 4;
   localparam int ASID_W   = 6;
   localparam int PPN_W    = 22;
   localparam int MODE_LSB = 28;
   localparam int ASID_LSB = 22;
   localparam int PPN_LSB  = 0;

   localparam logic [MODE_W-1:0] MODE_BARE = 4'd0;
   localparam logic [MODE_W-1:0] MODE_SV32 = 4'd1;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_REJECT  = 2'b01,
      ST_TIMEOUT = 2'b10
   } satp_status_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } satp_ctrl_state_e;

   function automatic logic [SATP_W-1:0] satp_pack(
      input logic [MODE_W-1:0] mode,
      input logic [ASID_W-1:0] asid,
      input logic [PPN_W-1:0]  ppn
   );
      return {mode, asid, ppn};
   endfunction

endpackage

// File: rtl/satp_drain_timer.sv
// ---------------------------------------------------------------------------
// satp_drain_timer
//  Counts busy cycles spent waiting for in-flight MMU walks to drain.
//  Saturating counter (never wraps) with synchronous clear and enable.
//  expired_o is high while the count sits at TIMEOUT-1, i.e. during the
//  TIMEOUT-th enabled cycle; TIMEOUT=0 disables expiry entirely.
// Ports
//  clk        in   clock
//  rst        in   asynchronous active-high reset
//  clr_i      in   clear count to zero (wins over enable)
//  en_i       in   increment count
//  expired_o  out  count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module satp_drain_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int  CW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit  HAS_TO = (TIMEOUT != 0);
   localparam logic [CW-1:0] LAST = HAS_TO ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired_o = HAS_TO && (cnt_q == LAST);

endmodule

// File: rtl/satp_switch_ctrl.sv
// ---------------------------------------------------------------------------
// satp_switch_ctrl
//  Owns the SV32 SATP register and sequences software writes to it. Writes
//  with MODE=0 are rejected; accepted writes always commit MODE=ENFORCED_MODE.
//  A write that changes ASID or PPN holds the MMU, waits for in-flight walks
//  to drain (with optional timeout abort), commits, then handshakes a TLB
//  flush before completing.
// Ports
//  clk, rst        clock, asynchronous active-high reset
//  req_valid/ready write request handshake from the CSR file
//  req_wdata       {MODE[31:28], ASID[27:22], PPN[21:0]}
//  rsp_valid       one-cycle completion pulse per accepted request
//  rsp_status      00 ok, 01 rejected, 10 drain timeout
//  satp_q          architectural SATP value
//  mmu_hold        block new MMU walks / TLB fills
//  mmu_busy        MMU has a walk in flight
//  flush_req       TLB flush request, held until flush_ack
//  flush_global    flush all entries (PPN changed) vs. ASID-tagged only
//  flush_asid      ASID to flush when flush_global=0
//  flush_ack       TLB flush complete
// ---------------------------------------------------------------------------
module satp_switch_ctrl
   import satp_pkg::*;
#(
   parameter logic [3:0]  ENFORCED_MODE = 4'd1,
   parameter int unsigned DRAIN_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [31:0] satp_q,
   output logic        mmu_hold,
   input  logic        mmu_busy,
   output logic        flush_req,
   output logic        flush_global,
   output logic [5:0]  flush_asid,
   input  logic        flush_ack
);

   satp_ctrl_state_e  state_q, state_d;
   logic [31:0]       satp_d;
   logic [ASID_W-1:0] pend_asid_q, pend_asid_d;
   logic [PPN_W-1:0]  pend_ppn_q, pend_ppn_d;
   logic              hold_q, hold_d;
   logic              freq_q, freq_d;
   logic              fglob_q, fglob_d;
   logic [ASID_W-1:0] fasid_q, fasid_d;
   logic              rsp_vld_q, rsp_vld_d;
   satp_status_e      rsp_st_q, rsp_st_d;

   logic              tmr_clr, tmr_en, tmr_expired;

   logic [MODE_W-1:0] wr_mode;
   logic [ASID_W-1:0] wr_asid;
   logic [PPN_W-1:0]  wr_ppn;
   logic [ASID_W-1:0] cur_asid;
   logic [PPN_W-1:0]  cur_ppn;

   assign wr_mode  = req_wdata[MODE_LSB +: MODE_W];
   assign wr_asid  = req_wdata[ASID_LSB +: ASID_W];
   assign wr_ppn   = req_wdata[PPN_LSB  +: PPN_W];
   assign cur_asid = satp_q[ASID_LSB +: ASID_W];
   assign cur_ppn  = satp_q[PPN_LSB  +: PPN_W];

   satp_drain_timer #(
      .TIMEOUT (DRAIN_TIMEOUT)
   ) u_drain_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      satp_d      = satp_q;
      pend_asid_d = pend_asid_q;
      pend_ppn_d  = pend_ppn_q;
      hold_d      = hold_q;
      freq_d      = freq_q;
      fglob_d     = fglob_q;
      fasid_d     = fasid_q;
      rsp_vld_d   = 1'b0;
      rsp_st_d    = ST_OK;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (wr_mode == MODE_BARE) begin
                  rsp_vld_d = 1'b1;
                  rsp_st_d  = ST_REJECT;
               end else if ((wr_asid == cur_asid) && (wr_ppn == cur_ppn)) begin
                  // No translation change: only MODE is re-asserted, no flush.
                  satp_d    = satp_pack(ENFORCED_MODE, wr_asid, wr_ppn);
                  rsp_vld_d = 1'b1;
                  rsp_st_d  = ST_OK;
               end else begin
                  pend_asid_d = wr_asid;
                  pend_ppn_d  = wr_ppn;
                  hold_d      = 1'b1;
                  tmr_clr     = 1'b1;
                  state_d     = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (!mmu_busy) begin
               satp_d  = satp_pack(ENFORCED_MODE, pend_asid_q, pend_ppn_q);
               // A PPN change invalidates every mapping; an ASID-only change
               // only needs the new ASID's stale entries removed.
               fglob_d = (pend_ppn_q != cur_ppn);
               fasid_d = pend_asid_q;
               freq_d  = 1'b1;
               state_d = FLUSH;
            end else if (tmr_expired) begin
               hold_d    = 1'b0;
               rsp_vld_d = 1'b1;
               rsp_st_d  = ST_TIMEOUT;
               state_d   = IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end

         FLUSH: begin
            if (flush_ack) begin
               freq_d    = 1'b0;
               hold_d    = 1'b0;
               rsp_vld_d = 1'b1;
               rsp_st_d  = ST_OK;
               state_d   = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         satp_q      <= satp_pack(ENFORCED_MODE, '0, '0);
         pend_asid_q <= '0;
         pend_ppn_q  <= '0;
         hold_q      <= 1'b0;
         freq_q      <= 1'b0;
         fglob_q     <= 1'b0;
         fasid_q     <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_st_q    <= ST_OK;
      end else begin
         state_q     <= state_d;
         satp_q      <= satp_d;
         pend_asid_q <= pend_asid_d;
         pend_ppn_q  <= pend_ppn_d;
         hold_q      <= hold_d;
         freq_q      <= freq_d;
         fglob_q     <= fglob_d;
         fasid_q     <= fasid_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_st_q    <= rsp_st_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = rsp_vld_q;
   assign rsp_status   = rsp_st_q;
   assign mmu_hold     = hold_q;
   assign flush_req    = freq_q;
   assign flush_global = fglob_q;
   assign flush_asid   = fasid_q;

endmodule

// File: tb/tb_satp_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_satp_switch_ctrl
//  Directed bench for satp_switch_ctrl (ENFORCED_MODE=1, DRAIN_TIMEOUT=16).
//  Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_satp_switch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [1:0]  rsp_status;
   logic [31:0] satp_q;
   logic        mmu_hold;
   logic        mmu_busy = 1'b0;
   logic        flush_req;
   logic        flush_global;
   logic [5:0]  flush_asid;
   logic        flush_ack = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   satp_switch_ctrl #(
      .ENFORCED_MODE (4'd1),
      .DRAIN_TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_status   (rsp_status),
      .satp_q       (satp_q),
      .mmu_hold     (mmu_hold),
      .mmu_busy     (mmu_busy),
      .flush_req    (flush_req),
      .flush_global (flush_global),
      .flush_asid   (flush_asid),
      .flush_ack    (flush_ack)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Single-cycle request for writes that complete without DRAIN/FLUSH.
   // Returns with the response cycle visible.
   task automatic quick_req(input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = '0;
   endtask

   // Full switch sequence. busy_n = clocks mmu_busy stays high, counting the
   // request cycle itself; ack_dly = FLUSH cycles before flush_ack.
   task automatic switch_op(
      input  logic [31:0] d,
      input  int          busy_n,
      input  int          ack_dly,
      output int          drain_cnt,
      output logic        got_rsp,
      output logic [1:0]  st,
      output logic        fg,
      output logic [5:0]  fa,
      output logic        hold_at_rsp
   );
      int busy_left;
      int fcyc;
      drain_cnt   = 0;
      got_rsp     = 1'b0;
      st          = 2'b11;
      fg          = 1'b0;
      fa          = '0;
      hold_at_rsp = 1'b1;
      fcyc        = 0;
      busy_left   = busy_n;
      @(negedge clk);
      req_valid = 1'b1;
      req_wdata = d;
      mmu_busy  = (busy_left > 0);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_wdata = '0;
         busy_left--;
         mmu_busy  = (busy_left > 0);
         if (rsp_valid) begin
            got_rsp     = 1'b1;
            st          = rsp_status;
            hold_at_rsp = mmu_hold | flush_req;
            flush_ack   = 1'b0;
            break;
         end
         if (flush_req) begin
            fg        = flush_global;
            fa        = flush_asid;
            flush_ack = (fcyc >= ack_dly);
            fcyc++;
         end else begin
            flush_ack = 1'b0;
            if (mmu_hold) drain_cnt++;
         end
      end
      mmu_busy  = 1'b0;
      flush_ack = 1'b0;
   endtask

   int         dc;
   logic       got, fg, hold_r;
   logic [1:0] st;
   logic [5:0] fa;
   int         stray_rsp;

   initial begin
      // 1. reset values
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_satp",   satp_q,       32'h1000_0000);
      chk("rst_ready",  32'(req_ready),    32'd1);
      chk("rst_rsp",    32'(rsp_valid),    32'd0);
      chk("rst_status", 32'(rsp_status),   32'd0);
      chk("rst_hold",   32'(mmu_hold),     32'd0);
      chk("rst_freq",   32'(flush_req),    32'd0);
      chk("rst_fglob",  32'(flush_global), 32'd0);
      chk("rst_fasid",  32'(flush_asid),   32'd0);

      // 2. MODE=0 write rejected
      quick_req(32'h0040_0123);
      chk("rej_rsp",    32'(rsp_valid),  32'd1);
      chk("rej_status", 32'(rsp_status), 32'd1);
      chk("rej_satp",   satp_q,          32'h1000_0000);
      chk("rej_hold",   32'(mmu_hold | flush_req), 32'd0);
      chk("rej_ready",  32'(req_ready),  32'd1);
      @(negedge clk);
      chk("rej_pulse",  32'(rsp_valid),  32'd0);

      // 4. ASID-only change, flush_ack 3 cycles after flush_req
      switch_op(32'h1080_0000, 0, 3, dc, got, st, fg, fa, hold_r);
      chk("asid_rsp",    32'(got),    32'd1);
      chk("asid_status", 32'(st),     32'd0);
      chk("asid_drain",  32'(dc),     32'd1);
      chk("asid_fglob",  32'(fg),     32'd0);
      chk("asid_fasid",  32'(fa),     32'd2);
      chk("asid_satp",   satp_q,      32'h1080_0000);
      chk("asid_hold",   32'(hold_r), 32'd0);

      // Move to 0x1040_0123 with flush_ack in the first FLUSH cycle
      switch_op(32'h1040_0123, 0, 0, dc, got, st, fg, fa, hold_r);
      chk("pre3_rsp",   32'(got), 32'd1);
      chk("pre3_fglob", 32'(fg),  32'd1);
      chk("pre3_fasid", 32'(fa),  32'd1);
      chk("pre3_satp",  satp_q,   32'h1040_0123);

      // 3. same ASID/PPN: completes without hold/flush
      quick_req(32'h1040_0123);
      chk("same_rsp",    32'(rsp_valid),  32'd1);
      chk("same_status", 32'(rsp_status), 32'd0);
      chk("same_hold",   32'(mmu_hold | flush_req), 32'd0);
      chk("same_satp",   satp_q,          32'h1040_0123);

      // 5. MODE=0 with PPN change still rejected
      quick_req(32'h0000_0456);
      chk("rej2_status", 32'(rsp_valid ? rsp_status : 2'b11), 32'd1);
      chk("rej2_hold",   32'(mmu_hold | flush_req), 32'd0);
      chk("rej2_satp",   satp_q, 32'h1040_0123);

      // 5. MODE forced, busy for 5 clocks -> 5 DRAIN cycles, global flush
      switch_op(32'h9000_0456, 5, 1, dc, got, st, fg, fa, hold_r);
      chk("ppn_rsp",    32'(got), 32'd1);
      chk("ppn_status", 32'(st),  32'd0);
      chk("ppn_drain",  32'(dc),  32'd5);
      chk("ppn_fglob",  32'(fg),  32'd1);
      chk("ppn_fasid",  32'(fa),  32'd0);
      chk("ppn_satp",   satp_q,   32'h1000_0456);

      // 6. drain timeout: busy stuck high
      switch_op(32'h1040_0456, 1000, 0, dc, got, st, fg, fa, hold_r);
      chk("to_rsp",    32'(got),    32'd1);
      chk("to_status", 32'(st),     32'd2);
      chk("to_drain",  32'(dc),     32'd16);
      chk("to_satp",   satp_q,      32'h1000_0456);
      chk("to_hold",   32'(hold_r), 32'd0);

      // 6. reset asserted during FLUSH
      @(negedge clk);
      req_valid = 1'b1;
      req_wdata = 32'h1080_0000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_drain", 32'(mmu_hold & ~flush_req), 32'd1);
      @(negedge clk);
      chk("mid_flush", 32'(flush_req), 32'd1);
      chk("mid_satp",  satp_q,         32'h1080_0000);
      #2 rst = 1'b1;
      #1;
      chk("mrst_satp",  satp_q,            32'h1000_0000);
      chk("mrst_freq",  32'(flush_req),    32'd0);
      chk("mrst_hold",  32'(mmu_hold),     32'd0);
      chk("mrst_fglob", 32'(flush_global), 32'd0);
      chk("mrst_fasid", 32'(flush_asid),   32'd0);
      chk("mrst_rsp",   32'(rsp_valid),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      stray_rsp = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) stray_rsp++;
      end
      chk("mrst_norsp", 32'(stray_rsp), 32'd0);
      chk("mrst_ready", 32'(req_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
